// File: rtl/regfile_pkg.sv
// Shared register-file geometry and writeback source numbering.
package regfile_pkg;
   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = '0;
   localparam int WB_NREQ = 3;
   localparam int WB_EX   = 0;
   localparam int WB_MEM  = 1;
   localparam int WB_LINK = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanned from rr_ptr.
// rr_ptr moves past the winner only on an accepted transfer (adv).
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         adv,
   output logic [N-1:0] gnt,
   output logic [2:0]   gnt_idx
);

   logic [2:0] rr_ptr;

   always_comb begin
      logic [3:0] idx;
      logic       found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, rr_ptr} + 4'(k);
         if (idx >= 4'(N)) idx = idx - 4'(N);
         for (int j = 0; j < N; j++) begin
            if (!found && idx == 4'(j) && req[j]) begin
               found   = 1'b1;
               gnt[j]  = 1'b1;
               gnt_idx = 3'(j);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= '0;
      else if (adv)
         rr_ptr <= (gnt_idx == 3'(N-1)) ? 3'd0 : gnt_idx + 3'd1;
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin share of the register-file write port; 1-cycle registered write, no buffering.
// Backpressure only via one-hot req_ready; writes to register 0 are accepted and dropped.
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int NREQ = WB_NREQ,
   parameter int AW   = REG_AW,
   parameter int DW   = REG_DW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic              rf_we,
   output logic [AW-1:0]     rf_waddr,
   output logic [DW-1:0]     rf_wdata,
   output logic [2:0]        grant_id,
   output logic [2**AW-1:0]  pending
);

   logic [NREQ-1:0] gnt;
   logic [2:0]      gnt_idx;
   logic            xfer;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   rr_arbiter #(.N(NREQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .adv     (xfer),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt & {NREQ{~rst}};
   assign xfer      = |req_ready;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_addr = req_addr[i*AW +: AW];
            sel_data = req_data[i*DW +: DW];
         end
      end
   end

   // Address and data follow every transfer, including dropped $zero writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         grant_id <= '0;
      end else if (xfer) begin
         rf_we    <= (sel_addr != REG_ZERO[AW-1:0]);
         rf_waddr <= sel_addr;
         rf_wdata <= sel_data;
         grant_id <= gnt_idx;
      end else begin
         rf_we    <= 1'b0;
      end
   end

   always_comb begin
      pending = '0;
      if (!rst) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) pending[req_addr[i*AW +: AW]] = 1'b1;
         end
         if (rf_we) pending[rf_waddr] = 1'b1;
         pending[0] = 1'b0;
      end
   end

endmodule
